// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : led_sequencer
//  Description : Register-programmed LED pattern sequencer with prescaled
//                step timing, one-shot or looping playback, and abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_sequencer (
    input  logic       system_clock_in,
    input  logic       system_reset,
    input  logic       cfg_write,
    input  logic [3:0] cfg_address,
    input  logic [7:0] cfg_data,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] led,
    output logic       busy,
    output logic       done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [7:0] c_PRESCALE_RST  = 8'hFF;
    localparam logic [2:0] c_LAST_STEP_RST = 3'd7;
    localparam int         c_NUM_PATTERNS  = 8;

    // ------------------------------------------------------------------
    // Configuration register file
    // ------------------------------------------------------------------
    logic [7:0] r_prescale;
    logic [2:0] r_last_step;
    logic       r_loop;
    logic [3:0] r_pattern [c_NUM_PATTERNS];

    logic       w_wr_prescale;
    logic       w_wr_last_step;
    logic       w_wr_loop;
    logic       w_wr_pattern;
    logic [2:0] w_pat_idx;

    assign w_wr_prescale  = cfg_write && (cfg_address == 4'd0);
    assign w_wr_last_step = cfg_write && (cfg_address == 4'd1);
    assign w_wr_loop      = cfg_write && (cfg_address == 4'd2);
    assign w_wr_pattern   = cfg_write && (cfg_address >= 4'd4) && (cfg_address <= 4'd11);
    // (addr - 4) mod 8 for the pattern window 4..11
    assign w_pat_idx      = {~cfg_address[2], cfg_address[1:0]};

    always_ff @(posedge system_clock_in or posedge system_reset) begin
        if (system_reset) begin
            r_prescale  <= c_PRESCALE_RST;
            r_last_step <= c_LAST_STEP_RST;
            r_loop      <= 1'b0;
        end else begin
            if (w_wr_prescale) begin
                r_prescale <= cfg_data;
            end
            if (w_wr_last_step) begin
                r_last_step <= cfg_data[2:0];
            end
            if (w_wr_loop) begin
                r_loop <= cfg_data[0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < c_NUM_PATTERNS; gi++) begin : g_pattern
            always_ff @(posedge system_clock_in or posedge system_reset) begin
                if (system_reset) begin
                    r_pattern[gi] <= 4'd0;
                end else if (w_wr_pattern && (w_pat_idx == 3'(gi))) begin
                    r_pattern[gi] <= cfg_data[3:0];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t     r_state;
    logic [2:0] r_step;
    logic [7:0] r_prescaler;
    logic [3:0] r_led;
    logic       r_done;

    state_t     w_state_next;
    logic [2:0] w_step_next;
    logic [7:0] w_prescaler_next;
    logic [3:0] w_led_next;
    logic       w_done_next;

    always_ff @(posedge system_clock_in or posedge system_reset) begin
        if (system_reset) begin
            r_state     <= IDLE;
            r_step      <= 3'd0;
            r_prescaler <= 8'd0;
            r_led       <= 4'd0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_step      <= w_step_next;
            r_prescaler <= w_prescaler_next;
            r_led       <= w_led_next;
            r_done      <= w_done_next;
        end
    end

    // Timing decisions use the registered config, so a same-cycle write
    // only matters from the following cycle on.
    always_comb begin
        w_state_next     = r_state;
        w_step_next      = r_step;
        w_prescaler_next = r_prescaler;
        w_led_next       = 4'd0;
        w_done_next      = 1'b0;

        case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    w_state_next     = RUN;
                    w_step_next      = 3'd0;
                    w_prescaler_next = r_prescale;
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_next     = IDLE;
                    w_step_next      = 3'd0;
                    w_prescaler_next = 8'd0;
                end else if (r_prescaler == 8'd0) begin
                    w_prescaler_next = r_prescale;
                    // >= rather than == so a shrinking last_step cannot strand us
                    if (r_step >= r_last_step) begin
                        if (r_loop) begin
                            w_step_next = 3'd0;
                        end else begin
                            w_state_next     = IDLE;
                            w_step_next      = 3'd0;
                            w_prescaler_next = 8'd0;
                            w_done_next      = 1'b1;
                        end
                    end else begin
                        w_step_next = r_step + 3'd1;
                    end
                end else begin
                    w_prescaler_next = r_prescaler - 8'd1;
                end
            end
            default: begin
                w_state_next     = IDLE;
                w_step_next      = 3'd0;
                w_prescaler_next = 8'd0;
            end
        endcase

        // Forward a same-cycle pattern write so the displayed entry is never stale
        if (w_state_next == RUN) begin
            if (w_wr_pattern && (w_pat_idx == w_step_next)) begin
                w_led_next = cfg_data[3:0];
            end else begin
                w_led_next = r_pattern[w_step_next];
            end
        end
    end

    assign led  = r_led;
    assign busy = (r_state == RUN);
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_sequencer
//  Description : Directed, table-driven self-checking bench for led_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_sequencer;

    logic       clk;
    logic       rst;
    logic       cfg_write;
    logic [3:0] cfg_address;
    logic [7:0] cfg_data;
    logic       start;
    logic       stop;
    logic [3:0] led;
    logic       busy;
    logic       done;

    int n_vec;
    int n_err;

    led_sequencer dut (
        .system_clock_in (clk),
        .system_reset    (rst),
        .cfg_write       (cfg_write),
        .cfg_address     (cfg_address),
        .cfg_data        (cfg_data),
        .start           (start),
        .stop            (stop),
        .led             (led),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       sp;
        logic       wr;
        logic [3:0] a;
        logic [7:0] d;
        logic [3:0] e_led;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vq[$];

    function automatic void tv(input logic st, input logic sp, input logic wr,
                               input logic [3:0] a, input logic [7:0] d,
                               input logic [3:0] el, input logic eb, input logic ed);
        vec_t v;
        v.st = st; v.sp = sp; v.wr = wr; v.a = a; v.d = d;
        v.e_led = el; v.e_busy = eb; v.e_done = ed;
        vq.push_back(v);
    endfunction

    // Expected led for cycle N+k of a 4-step, 3-cycle-per-step run of 1,2,4,8
    function automatic logic [3:0] seq_led(input int k);
        case (((k - 1) / 3) % 4)
            0:       return 4'd1;
            1:       return 4'd2;
            2:       return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    task automatic cmp(input string nm, input logic [3:0] el, input logic eb, input logic ed);
        n_vec++;
        if (led !== el || busy !== eb || done !== ed) begin
            n_err++;
            $display("FAIL %s: led/busy/done got %h/%b/%b expected %h/%b/%b",
                     nm, led, busy, done, el, eb, ed);
        end
    endtask

    task automatic cyc(input logic st, input logic sp, input logic wr,
                       input logic [3:0] a, input logic [7:0] d,
                       input logic [3:0] el, input logic eb, input logic ed,
                       input string nm);
        start = st; stop = sp; cfg_write = wr; cfg_address = a; cfg_data = d;
        @(posedge clk);
        @(negedge clk);
        cmp(nm, el, eb, ed);
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d, input logic el, input logic eb);
        cyc(1'b0, 1'b0, 1'b1, a, d, {3'd0, el} & 4'd0, eb, 1'b0, "cfg_write");
    endtask

    task automatic setup_run(input logic lp);
        wr_reg(4'd0, 8'd2, 1'b0, 1'b0);
        wr_reg(4'd1, 8'd3, 1'b0, 1'b0);
        wr_reg(4'd4, 8'd1, 1'b0, 1'b0);
        wr_reg(4'd5, 8'd2, 1'b0, 1'b0);
        wr_reg(4'd6, 8'd4, 1'b0, 1'b0);
        wr_reg(4'd7, 8'd8, 1'b0, 1'b0);
        wr_reg(4'd2, {7'd0, lp}, 1'b0, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        cfg_write = 1'b0; cfg_address = 4'd0; cfg_data = 8'd0;

        // ---- vector table ----
        // one-shot config: prescale=2, last_step=3, pattern 1,2,4,8, loop=0
        tv(0, 0, 1, 4'd0, 8'd2, 4'd0, 0, 0);
        tv(0, 0, 1, 4'd1, 8'd3, 4'd0, 0, 0);
        tv(0, 0, 1, 4'd4, 8'd1, 4'd0, 0, 0);
        tv(0, 0, 1, 4'd5, 8'd2, 4'd0, 0, 0);
        tv(0, 0, 1, 4'd6, 8'd4, 4'd0, 0, 0);
        tv(0, 0, 1, 4'd7, 8'd8, 4'd0, 0, 0);
        tv(0, 0, 1, 4'd2, 8'd0, 4'd0, 0, 0);
        // start and stop together in IDLE: stays idle
        tv(1, 1, 0, 4'd0, 8'd0, 4'd0, 0, 0);
        // one-shot, start held high mid-run must not disturb it
        tv(1, 0, 0, 4'd0, 8'd0, 4'd1, 1, 0);
        for (int k = 2; k <= 12; k++)
            tv((k >= 5 && k <= 8), 0, 0, 4'd0, 8'd0, seq_led(k), 1, 0);
        tv(0, 0, 0, 4'd0, 8'd0, 4'd0, 0, 1);
        tv(0, 0, 0, 4'd0, 8'd0, 4'd0, 0, 0);
        // stop on the final-step tick: no done
        tv(1, 0, 0, 4'd0, 8'd0, 4'd1, 1, 0);
        for (int k = 2; k <= 12; k++)
            tv(0, 0, 0, 4'd0, 8'd0, seq_led(k), 1, 0);
        tv(0, 1, 0, 4'd0, 8'd0, 4'd0, 0, 0);
        tv(0, 0, 0, 4'd0, 8'd0, 4'd0, 0, 0);
        // prescale=0, last_step=0, pattern[0]=F
        tv(0, 0, 1, 4'd0, 8'd0,  4'd0, 0, 0);
        tv(0, 0, 1, 4'd1, 8'd0,  4'd0, 0, 0);
        tv(0, 0, 1, 4'd4, 8'h0F, 4'd0, 0, 0);
        tv(1, 0, 0, 4'd0, 8'd0,  4'hF, 1, 0);
        tv(0, 0, 0, 4'd0, 8'd0,  4'd0, 0, 1);
        tv(0, 0, 0, 4'd0, 8'd0,  4'd0, 0, 0);

        // ---- reset state, checked before any clock edge ----
        #3;
        cmp("reset_async", 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cmp("reset_idle", 4'd0, 1'b0, 1'b0);

        // ---- table ----
        for (int i = 0; i < vq.size(); i++) begin
            cyc(vq[i].st, vq[i].sp, vq[i].wr, vq[i].a, vq[i].d,
                vq[i].e_led, vq[i].e_busy, vq[i].e_done, $sformatf("vec[%0d]", i));
        end

        // ---- loop mode: 40 cycles of repeating 1,2,4,8, then stop mid-step ----
        setup_run(1'b1);
        cyc(1, 0, 0, 4'd0, 8'd0, 4'd1, 1, 0, "loop_start");
        for (int k = 2; k <= 41; k++)
            cyc(0, 0, 0, 4'd0, 8'd0, seq_led(k), 1, 0, $sformatf("loop_k%0d", k));
        cyc(0, 1, 0, 4'd0, 8'd0, 4'd0, 0, 0, "loop_stop");
        cyc(0, 0, 0, 4'd0, 8'd0, 4'd0, 0, 0, "loop_after_stop");

        // ---- live reconfiguration: last_step=1 written while on step 3 ----
        wr_reg(4'd2, 8'd0, 1'b0, 1'b0);
        cyc(1, 0, 0, 4'd0, 8'd0, 4'd1, 1, 0, "reconf_start");
        for (int k = 2; k <= 10; k++)
            cyc(0, 0, 0, 4'd0, 8'd0, seq_led(k), 1, 0, $sformatf("reconf_k%0d", k));
        cyc(0, 0, 1, 4'd1, 8'd1, 4'd8, 1, 0, "reconf_write");
        cyc(0, 0, 0, 4'd0, 8'd0, 4'd8, 1, 0, "reconf_k12");
        cyc(0, 0, 0, 4'd0, 8'd0, 4'd0, 0, 1, "reconf_done");
        wr_reg(4'd1, 8'd3, 1'b0, 1'b0);

        // ---- asynchronous reset mid-run ----
        cyc(1, 0, 0, 4'd0, 8'd0, 4'd1, 1, 0, "rstrun_start");
        for (int k = 2; k <= 5; k++)
            cyc(0, 0, 0, 4'd0, 8'd0, seq_led(k), 1, 0, $sformatf("rstrun_k%0d", k));
        @(posedge clk);
        #2 rst = 1'b1;
        #1 cmp("rst_mid_run", 4'd0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        @(negedge clk);
        cmp("rst_after_edge", 4'd0, 1'b0, 1'b0);
        // defaults: prescale=255, last_step=7, patterns 0, loop 0
        cyc(1, 0, 0, 4'd0, 8'd0, 4'd0, 1, 0, "dflt_start");
        for (int k = 2; k <= 2048; k++)
            cyc(0, 0, 0, 4'd0, 8'd0, 4'd0, 1, 0, $sformatf("dflt_k%0d", k));
        cyc(0, 0, 0, 4'd0, 8'd0, 4'd0, 0, 1, "dflt_done");
        cyc(0, 0, 0, 4'd0, 8'd0, 4'd0, 0, 0, "dflt_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
